// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA pixel path.
package vga_pkg;

    typedef logic [11:0] color_t;

    // Icon pixels equal to this value let the world map show through.
    localparam color_t COLOR_TRANSPARENT = 12'h000;
    localparam color_t COLOR_BLACK       = 12'h000;
    localparam color_t COLOR_WHITE       = 12'hFFF;
    localparam color_t COLOR_RED         = 12'hF00;
    localparam color_t COLOR_GREEN       = 12'h0F0;

    typedef enum logic [1:0] {
        WORLD_BG   = 2'b00,
        WORLD_LINE = 2'b01,
        WORLD_OBST = 2'b10,
        WORLD_RSVD = 2'b11
    } world_code_t;

    typedef enum logic {
        BLINK_VISIBLE = 1'b0,
        BLINK_HIDDEN  = 1'b1
    } blink_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/vga_colorizer_pipe_delay_line.sv
// Parameterised shift register; collapses to a plain wire when DEPTH is 0.
module delay_line #(
    parameter int              WIDTH     = 1,
    parameter int              DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] d_out
);

    if (DEPTH == 0) begin : g_wire
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ reset;
        assign d_out = d_in;
    end else begin : g_shift
        logic [WIDTH-1:0] stage_q [DEPTH];
        logic [WIDTH-1:0] stage_d [DEPTH];

        // Next value of every stage: input enters stage 0, the rest shift by one.
        always_comb begin
            stage_d[0] = d_in;
            for (int i = 1; i < DEPTH; i++) begin
                stage_d[i] = stage_q[i-1];
            end
        end

        // Stage registers, cleared to the idle value on reset.
        always_ff @(posedge clk) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (reset) begin
                    stage_q[i] <= RESET_VAL;
                end else begin
                    stage_q[i] <= stage_d[i];
                end
            end
        end

        assign d_out = stage_q[DEPTH-1];
    end

endmodule

// File: rtl/vga_colorizer_pipe.sv
// Final VGA pixel stage: aligns timing/world/icon, applies icon priority and blink, registers pins.
//
// Blink states:
//   state          | meaning
//   BLINK_VISIBLE  | icon pixels drawn over the world map
//   BLINK_HIDDEN   | icon treated as transparent, world shows through
module vga_colorizer_pipe
    import vga_pkg::*;
#(
    parameter int     ICON_LATENCY  = 2,
    parameter int     WORLD_LATENCY = 1,
    parameter int     BLINK_FRAMES  = 30,
    parameter logic   SYNC_IDLE     = 1'b1,
    parameter color_t BG_COLOR      = COLOR_WHITE,
    parameter color_t LINE_COLOR    = COLOR_BLACK,
    parameter color_t OBST_COLOR    = COLOR_RED,
    parameter color_t RSVD_COLOR    = COLOR_GREEN
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        video_on,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic [1:0]  world_pixel,
    input  logic [11:0] icon,
    input  logic        blink_en,
    output logic [3:0]  vga_red,
    output logic [3:0]  vga_green,
    output logic [3:0]  vga_blue,
    output logic        vga_hsync,
    output logic        vga_vsync,
    output logic [15:0] frame_cnt
);

    localparam int ALIGN_D = max_int(ICON_LATENCY, WORLD_LATENCY);
    localparam int CNT_W   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

    logic        video_on_a;
    logic        hsync_a;
    logic        vsync_a;
    logic [1:0]  world_a;
    color_t      icon_a;

    delay_line #(.WIDTH(1), .DEPTH(ALIGN_D), .RESET_VAL(1'b0)) u_dly_video (
        .clk(clk), .reset(reset), .d_in(video_on), .d_out(video_on_a)
    );
    delay_line #(.WIDTH(1), .DEPTH(ALIGN_D), .RESET_VAL(SYNC_IDLE)) u_dly_hsync (
        .clk(clk), .reset(reset), .d_in(hsync_in), .d_out(hsync_a)
    );
    delay_line #(.WIDTH(1), .DEPTH(ALIGN_D), .RESET_VAL(SYNC_IDLE)) u_dly_vsync (
        .clk(clk), .reset(reset), .d_in(vsync_in), .d_out(vsync_a)
    );
    delay_line #(.WIDTH(2), .DEPTH(ALIGN_D - WORLD_LATENCY), .RESET_VAL(2'b00)) u_dly_world (
        .clk(clk), .reset(reset), .d_in(world_pixel), .d_out(world_a)
    );
    delay_line #(.WIDTH(12), .DEPTH(ALIGN_D - ICON_LATENCY), .RESET_VAL(COLOR_TRANSPARENT)) u_dly_icon (
        .clk(clk), .reset(reset), .d_in(icon), .d_out(icon_a)
    );

    color_t       rgb_q,  rgb_d;
    logic         hsync_q, hsync_d;
    logic         vsync_q, vsync_d;
    logic         vsync_prev_q, vsync_prev_d;
    logic [15:0]  frame_cnt_q, frame_cnt_d;
    logic         frame_edge;
    blink_state_t blink_state_q, blink_state_d;
    logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
    color_t       world_color;

    // Pixel mux on aligned signals: blanking, then visible icon, then world colour.
    always_comb begin
        world_color = BG_COLOR;
        case (world_a)
            WORLD_BG:   world_color = BG_COLOR;
            WORLD_LINE: world_color = LINE_COLOR;
            WORLD_OBST: world_color = OBST_COLOR;
            WORLD_RSVD: world_color = RSVD_COLOR;
            default:    world_color = BG_COLOR;
        endcase
        rgb_d = world_color;
        if (!video_on_a) begin
            rgb_d = COLOR_BLACK;
        end else if ((icon_a != COLOR_TRANSPARENT) && (blink_state_q == BLINK_VISIBLE)) begin
            rgb_d = icon_a;
        end
        hsync_d = hsync_a;
        vsync_d = vsync_a;
    end

    // Output register keeps RGB and syncs on the same clock.
    always_ff @(posedge clk) begin
        if (reset) begin
            rgb_q   <= COLOR_BLACK;
            hsync_q <= SYNC_IDLE;
            vsync_q <= SYNC_IDLE;
        end else begin
            rgb_q   <= rgb_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
        end
    end

    // Frame edge on the undelayed vsync going from idle to active; frame counter wraps.
    always_comb begin
        frame_edge   = (vsync_in != SYNC_IDLE) && (vsync_prev_q == SYNC_IDLE);
        vsync_prev_d = vsync_in;
        frame_cnt_d  = frame_edge ? (frame_cnt_q + 16'd1) : frame_cnt_q;
    end

    // Previous-vsync flag and frame counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            vsync_prev_q <= SYNC_IDLE;
            frame_cnt_q  <= 16'd0;
        end else begin
            vsync_prev_q <= vsync_prev_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    // Blink next-state: disable wins over a coincident frame edge.
    always_comb begin
        blink_state_d = blink_state_q;
        blink_cnt_d   = blink_cnt_q;
        if (!blink_en) begin
            blink_state_d = BLINK_VISIBLE;
            blink_cnt_d   = '0;
        end else if (frame_edge) begin
            if (blink_cnt_q == CNT_LAST) begin
                blink_cnt_d   = '0;
                blink_state_d = (blink_state_q == BLINK_VISIBLE) ? BLINK_HIDDEN : BLINK_VISIBLE;
            end else begin
                blink_cnt_d = blink_cnt_q + CNT_W'(1);
            end
        end
    end

    // Blink state and frame-within-half-period counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            blink_state_q <= BLINK_VISIBLE;
            blink_cnt_q   <= '0;
        end else begin
            blink_state_q <= blink_state_d;
            blink_cnt_q   <= blink_cnt_d;
        end
    end

    assign vga_red   = rgb_q[11:8];
    assign vga_green = rgb_q[7:4];
    assign vga_blue  = rgb_q[3:0];
    assign vga_hsync = hsync_q;
    assign vga_vsync = vsync_q;
    assign frame_cnt = frame_cnt_q;

endmodule
